// File: rtl/audio_pkg.sv
// Shared types and constants for the audio input path receivers.
package audio_pkg;

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_DELAY = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } rx_state_e;

  localparam int unsigned MODE_I2S = 0;
  localparam int unsigned MODE_LJ  = 1;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_stereo.sv
// I2S / left-justified stereo ADC receiver: deserialises each LRCK half-frame into a
// tagged word, holds the latest left/right pair and flags half-frames that end early.
module i2s_rx_stereo
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MODE       = 0,
  parameter int unsigned LEFT_LEVEL = 0
) (
  input  logic                  i_bclk,
  input  logic                  i_rst,
  input  logic                  i_adclrck,
  input  logic                  i_adcdat,
  input  logic                  i_err_clr,
  output logic [DATA_WIDTH-1:0] o_sample,
  output logic                  o_channel,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_left,
  output logic [DATA_WIDTH-1:0] o_right,
  output logic                  o_pair_valid,
  output logic                  o_short_err
);

  localparam int unsigned     CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]   FULL     = CW'(DATA_WIDTH);
  localparam logic            LEFT_BIT = 1'(LEFT_LEVEL);

  rx_state_e             state_q, state_d, cur_c;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_base_c, cnt_inc_c;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, word_c;
  logic                  ch_q, ch_d;
  logic                  lrck_q, armed_q, edge_c;
  logic                  commit_c, commit_ch_c, set_err_c;

  logic [DATA_WIDTH-1:0] sample_q, sample_d, left_q, left_d, right_q, right_d;
  logic                  channel_q, channel_d, valid_q, valid_d;
  logic                  pair_q, pair_d, err_q, err_d, last_left_q, last_left_d;

  // armed_q masks the first cycle after reset, when lrck_q has not yet tracked the pin
  assign edge_c = armed_q & (i_adclrck ^ lrck_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ch_d        = ch_q;
    cur_c       = state_q;
    cnt_base_c  = cnt_q;
    commit_c    = 1'b0;
    commit_ch_c = ch_q;
    word_c      = '0;
    set_err_c   = 1'b0;

    // An edge closes the running word (short if incomplete) and restarts capture.
    // In I2S mode the edge cycle itself is the one-bit delay slot.
    if (edge_c) begin
      if ((state_q == S_SHIFT || state_q == S_DELAY) && cnt_q < FULL) begin
        set_err_c = 1'b1;
        if (cnt_q != '0) begin
          commit_c = 1'b1;
          word_c   = shift_q << (FULL - cnt_q);
        end
      end
      ch_d       = (i_adclrck != LEFT_BIT);
      cur_c      = (MODE == MODE_I2S) ? S_DELAY : S_SHIFT;
      cnt_base_c = '0;
    end

    cnt_inc_c = cnt_base_c + CW'(1);

    case (cur_c)
      S_DELAY: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        shift_d = {shift_q[DATA_WIDTH-2:0], i_adcdat};
        cnt_d   = cnt_inc_c;
        state_d = S_SHIFT;
        if (cnt_inc_c == FULL) begin
          commit_c    = 1'b1;
          commit_ch_c = ch_d;
          word_c      = {shift_q[DATA_WIDTH-2:0], i_adcdat};
          state_d     = S_DONE;
        end
      end
      default: state_d = cur_c;
    endcase
  end

  // Output registers: committed word, held stereo pair and sticky error
  always_comb begin
    valid_d     = commit_c;
    sample_d    = commit_c ? word_c : sample_q;
    channel_d   = commit_c ? commit_ch_c : channel_q;
    left_d      = (commit_c && commit_ch_c == CH_LEFT) ? word_c : left_q;
    right_d     = (commit_c && commit_ch_c == CH_RIGHT) ? word_c : right_q;
    pair_d      = commit_c && commit_ch_c == CH_RIGHT && last_left_q;
    last_left_d = commit_c ? (commit_ch_c == CH_LEFT) : last_left_q;
    err_d       = set_err_c | (err_q & ~i_err_clr);
  end

  always_ff @(posedge i_bclk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_SYNC;
      cnt_q       <= '0;
      shift_q     <= '0;
      ch_q        <= 1'b0;
      lrck_q      <= 1'b0;
      armed_q     <= 1'b0;
      sample_q    <= '0;
      channel_q   <= 1'b0;
      valid_q     <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      pair_q      <= 1'b0;
      err_q       <= 1'b0;
      last_left_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ch_q        <= ch_d;
      lrck_q      <= i_adclrck;
      armed_q     <= 1'b1;
      sample_q    <= sample_d;
      channel_q   <= channel_d;
      valid_q     <= valid_d;
      left_q      <= left_d;
      right_q     <= right_d;
      pair_q      <= pair_d;
      err_q       <= err_d;
      last_left_q <= last_left_d;
    end
  end

  assign o_sample     = sample_q;
  assign o_channel    = channel_q;
  assign o_valid      = valid_q;
  assign o_left       = left_q;
  assign o_right      = right_q;
  assign o_pair_valid = pair_q;
  assign o_short_err  = err_q;

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Directed bench for i2s_rx_stereo: four instances cover I2S, left-justified,
// 24-bit short-frame and inverted-LRCK configurations.
module tb_i2s_rx_stereo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_clr = 1'b0;
  logic lr [4];
  logic dat [4];

  always #5 clk = ~clk;

  logic [15:0] s0, l0, r0, s1, l1, r1, s3, l3, r3;
  logic [23:0] s2, l2, r2;
  logic        v0, c0, p0, e0, v1, c1, p1, e1, v2, c2, p2, e2, v3, c3, p3, e3;

  i2s_rx_stereo #(.DATA_WIDTH(16), .MODE(0), .LEFT_LEVEL(0)) u0 (
    .i_bclk(clk), .i_rst(rst), .i_adclrck(lr[0]), .i_adcdat(dat[0]), .i_err_clr(err_clr),
    .o_sample(s0), .o_channel(c0), .o_valid(v0), .o_left(l0), .o_right(r0),
    .o_pair_valid(p0), .o_short_err(e0));
  i2s_rx_stereo #(.DATA_WIDTH(16), .MODE(1), .LEFT_LEVEL(0)) u1 (
    .i_bclk(clk), .i_rst(rst), .i_adclrck(lr[1]), .i_adcdat(dat[1]), .i_err_clr(err_clr),
    .o_sample(s1), .o_channel(c1), .o_valid(v1), .o_left(l1), .o_right(r1),
    .o_pair_valid(p1), .o_short_err(e1));
  i2s_rx_stereo #(.DATA_WIDTH(24), .MODE(0), .LEFT_LEVEL(0)) u2 (
    .i_bclk(clk), .i_rst(rst), .i_adclrck(lr[2]), .i_adcdat(dat[2]), .i_err_clr(err_clr),
    .o_sample(s2), .o_channel(c2), .o_valid(v2), .o_left(l2), .o_right(r2),
    .o_pair_valid(p2), .o_short_err(e2));
  i2s_rx_stereo #(.DATA_WIDTH(16), .MODE(0), .LEFT_LEVEL(1)) u3 (
    .i_bclk(clk), .i_rst(rst), .i_adclrck(lr[3]), .i_adcdat(dat[3]), .i_err_clr(err_clr),
    .o_sample(s3), .o_channel(c3), .o_valid(v3), .o_left(l3), .o_right(r3),
    .o_pair_valid(p3), .o_short_err(e3));

  logic [31:0] s_w [4], l_w [4], r_w [4];
  logic        v_w [4], c_w [4], p_w [4], e_w [4];

  always_comb begin
    s_w[0] = 32'(s0); l_w[0] = 32'(l0); r_w[0] = 32'(r0);
    s_w[1] = 32'(s1); l_w[1] = 32'(l1); r_w[1] = 32'(r1);
    s_w[2] = 32'(s2); l_w[2] = 32'(l2); r_w[2] = 32'(r2);
    s_w[3] = 32'(s3); l_w[3] = 32'(l3); r_w[3] = 32'(r3);
    v_w[0] = v0; v_w[1] = v1; v_w[2] = v2; v_w[3] = v3;
    c_w[0] = c0; c_w[1] = c1; c_w[2] = c2; c_w[3] = c3;
    p_w[0] = p0; p_w[1] = p1; p_w[2] = p2; p_w[3] = p3;
    e_w[0] = e0; e_w[1] = e1; e_w[2] = e2; e_w[3] = e3;
  end

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          vcnt [4] = '{0, 0, 0, 0};
  int          pcnt [4] = '{0, 0, 0, 0};
  int          edge_cyc [4] = '{0, 0, 0, 0};
  int          last_dly [4] = '{0, 0, 0, 0};
  logic [31:0] last_s [4];
  logic        last_c [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse: word, channel and distance from the LRCK edge drive
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (v_w[i] === 1'b1) begin
        vcnt[i]     = vcnt[i] + 1;
        last_s[i]   = s_w[i];
        last_c[i]   = c_w[i];
        last_dly[i] = cyc - edge_cyc[i];
      end
      if (p_w[i] === 1'b1) pcnt[i] = pcnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive len BCLK cycles of one half-frame; w holds nb bits, MSB first
  task automatic half(input int u, input logic lv, input logic [31:0] w,
                      input int nb, input int len, input bit lj);
    for (int c = 0; c < len; c++) begin
      int idx;
      @(negedge clk);
      if (c == 0 && lr[u] !== lv) edge_cyc[u] = cyc;
      idx    = lj ? c : c - 1;
      lr[u]  = lv;
      dat[u] = (idx >= 0 && idx < nb) ? w[nb-1-idx] : 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v_before, p_before;
    for (int i = 0; i < 4; i++) begin
      lr[i]  = 1'b0;
      dat[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sample", s_w[0], 32'h0);
    chk("rst_valid", 32'(v_w[0]), 32'h0);
    chk("rst_left", l_w[2], 32'h0);
    chk("rst_right", r_w[2], 32'h0);
    chk("rst_err", 32'(e_w[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // I2S, 16 bit: the leading half with no LRCK edge is discarded
    half(0, 1'b0, 32'hA5C3, 16, 32, 1'b0);
    chk("i2s_partial_cnt", 32'(vcnt[0]), 32'd0);
    half(0, 1'b1, 32'h1234, 16, 32, 1'b0);
    chk("i2s_r1_cnt", 32'(vcnt[0]), 32'd1);
    chk("i2s_r1_word", last_s[0], 32'h1234);
    chk("i2s_r1_ch", 32'(last_c[0]), 32'd1);
    chk("i2s_r1_nopair", 32'(pcnt[0]), 32'd0);
    chk("i2s_latency", 32'(last_dly[0]), 32'd17);
    half(0, 1'b0, 32'hA5C3, 16, 32, 1'b0);
    chk("i2s_l_word", last_s[0], 32'hA5C3);
    chk("i2s_l_ch", 32'(last_c[0]), 32'd0);
    chk("i2s_l_hold", l_w[0], 32'hA5C3);
    half(0, 1'b1, 32'h1234, 16, 32, 1'b0);
    chk("i2s_r2_word", last_s[0], 32'h1234);
    chk("i2s_r2_pair", 32'(pcnt[0]), 32'd1);
    chk("i2s_r2_hold", r_w[0], 32'h1234);
    chk("i2s_err", 32'(e_w[0]), 32'h0);
    chk("i2s_cnt", 32'(vcnt[0]), 32'd3);

    // Left-justified: same words, valid one cycle earlier after the edge
    half(1, 1'b0, 32'hA5C3, 16, 32, 1'b1);
    chk("lj_partial_cnt", 32'(vcnt[1]), 32'd0);
    half(1, 1'b1, 32'h1234, 16, 32, 1'b1);
    chk("lj_r1_word", last_s[1], 32'h1234);
    chk("lj_latency", 32'(last_dly[1]), 32'd16);
    half(1, 1'b0, 32'hA5C3, 16, 32, 1'b1);
    chk("lj_l_word", last_s[1], 32'hA5C3);
    chk("lj_l_ch", 32'(last_c[1]), 32'd0);
    half(1, 1'b1, 32'h1234, 16, 32, 1'b1);
    chk("lj_r2_ch", 32'(last_c[1]), 32'd1);
    chk("lj_r2_pair", 32'(pcnt[1]), 32'd1);
    chk("lj_err", 32'(e_w[1]), 32'h0);

    // 24-bit receiver fed a 16-bit left word: zero-padded commit and sticky error
    half(2, 1'b1, 32'h123456, 24, 32, 1'b0);
    chk("w24_full_word", last_s[2], 32'h123456);
    chk("w24_full_err", 32'(e_w[2]), 32'h0);
    half(2, 1'b0, 32'hBEEF, 16, 17, 1'b0);
    half(2, 1'b1, 32'h0, 24, 3, 1'b0);
    chk("w24_short_word", last_s[2], 32'hBEEF00);
    chk("w24_short_ch", 32'(last_c[2]), 32'd0);
    chk("w24_short_left", l_w[2], 32'hBEEF00);
    chk("w24_short_err", 32'(e_w[2]), 32'h1);
    chk("w24_short_lat", 32'(last_dly[2]), 32'd1);
    half(2, 1'b1, 32'h0, 24, 29, 1'b0);
    chk("w24_right_cnt", 32'(vcnt[2]), 32'd3);
    chk("w24_right_word", last_s[2], 32'h0);
    chk("w24_pair", 32'(pcnt[2]), 32'd1);
    chk("w24_err_sticky", 32'(e_w[2]), 32'h1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("w24_err_clr", 32'(e_w[2]), 32'h0);

    // 24-bit words into the 16-bit receiver: truncated, no error
    half(0, 1'b0, 32'h89ABCD, 24, 32, 1'b0);
    chk("trunc_l_word", last_s[0], 32'h89AB);
    chk("trunc_l_err", 32'(e_w[0]), 32'h0);
    half(0, 1'b1, 32'h89ABCD, 24, 32, 1'b0);
    chk("trunc_r_word", last_s[0], 32'h89AB);
    chk("trunc_pair", 32'(pcnt[0]), 32'd2);

    // LRCK high means left
    half(3, 1'b1, 32'h0F0F, 16, 32, 1'b0);
    chk("ll1_ch", 32'(last_c[3]), 32'd0);
    chk("ll1_left", l_w[3], 32'h0F0F);
    half(3, 1'b0, 32'h5555, 16, 32, 1'b0);
    chk("ll1_r_ch", 32'(last_c[3]), 32'd1);
    chk("ll1_right", r_w[3], 32'h5555);
    chk("ll1_pair", 32'(pcnt[3]), 32'd1);

    // Reset after seven bits of a left word, then resynchronise
    half(0, 1'b0, 32'h1357, 16, 8, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_sample", s_w[0], 32'h0);
    chk("mrst_left", l_w[0], 32'h0);
    chk("mrst_right", r_w[0], 32'h0);
    chk("mrst_ch", 32'(c_w[0]), 32'h0);
    chk("mrst_valid", 32'(v_w[0]), 32'h0);
    chk("mrst_pair", 32'(p_w[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    v_before = vcnt[0];
    p_before = pcnt[0];
    half(0, 1'b0, 32'h2468, 16, 32, 1'b0);
    chk("mrst_ignored", 32'(vcnt[0] - v_before), 32'd0);
    half(0, 1'b1, 32'h2468, 16, 32, 1'b0);
    chk("mrst_r_word", last_s[0], 32'h2468);
    chk("mrst_r_nopair", 32'(pcnt[0] - p_before), 32'd0);
    half(0, 1'b0, 32'h1357, 16, 32, 1'b0);
    chk("mrst_l_word", last_s[0], 32'h1357);
    chk("mrst_l_ch", 32'(last_c[0]), 32'd0);
    chk("mrst_cnt", 32'(vcnt[0] - v_before), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
